// File: rtl/camera_frame_parser.sv
// Camera UART frame parser: AA 55 + 7 payload bytes + additive checksum -> one target command.
// Latency: valid pulses in the cycle after the edge following the checksum byte (best case).
// Backpressure: one pending slot held while arm_ready is low; newer good frames overwrite it (drop_cnt).
//
// Ports: sys_clk/sys_rst_n (async active-low); rx_data/rx_valid byte strobe from UART;
//        arm_ready sequencer idle level; x_data/y_data/angle_bias/warehouse_nob/color command
//        outputs updated with the 1-cycle valid pulse; frame_err 1-cycle pulse on checksum,
//        range or inter-byte gap failure; drop_cnt saturating count of overwritten commands.
module camera_frame_parser #(
    parameter int unsigned X_MAX      = 319,
    parameter int unsigned Y_MAX      = 239,
    parameter int unsigned WH_MAX     = 6,
    parameter int unsigned GAP_CYCLES = 50_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        arm_ready,
    output logic [8:0]  x_data,
    output logic [7:0]  y_data,
    output logic [11:0] angle_bias,
    output logic [5:0]  warehouse_nob,
    output logic [3:0]  color,
    output logic        valid,
    output logic        frame_err,
    output logic [7:0]  drop_cnt
);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [8:0] X_LIM  = 9'(X_MAX);
    localparam logic [7:0] Y_LIM  = 8'(Y_MAX);
    localparam logic [5:0] WH_LIM = 6'(WH_MAX);

    typedef enum logic [1:0] {HUNT_A, HUNT_B, PAYLOAD, CSUM} state_t;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] angle;
        logic [5:0]  wh;
        logic [3:0]  color;
    } cmd_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    cmd_t             frm_q, frm_d;    // fields of the frame being received
    cmd_t             buf_q, buf_d;    // pending command
    cmd_t             out_q, out_d;    // last released command
    logic             pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       drop_q, drop_d;
    logic             frame_good;
    logic             release_cmd;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        gap_d       = '0;
        frm_d       = frm_q;
        buf_d       = buf_q;
        out_d       = out_q;
        pend_d      = pend_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        drop_d      = drop_q;
        frame_good  = 1'b0;
        release_cmd = 1'b0;

        // Inter-byte gap watchdog, only armed once a frame has started.
        if (state_q != HUNT_A && !rx_valid) begin
            if (gap_q == GAP_LAST) begin
                state_d = HUNT_A;
                err_d   = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        if (rx_valid) begin
            unique case (state_q)
                HUNT_A: begin
                    if (rx_data == 8'hAA) state_d = HUNT_B;
                end
                HUNT_B: begin
                    // A repeated AA may be the real start of frame, so keep waiting for 55.
                    if (rx_data == 8'h55) begin
                        state_d = PAYLOAD;
                        idx_d   = 3'd0;
                        sum_d   = 8'd0;
                    end else if (rx_data != 8'hAA) begin
                        state_d = HUNT_A;
                    end
                end
                PAYLOAD: begin
                    sum_d = sum_q + rx_data;
                    case (idx_q)
                        3'd0:    frm_d.x[8]         = rx_data[0];
                        3'd1:    frm_d.x[7:0]       = rx_data;
                        3'd2:    frm_d.y            = rx_data;
                        3'd3:    frm_d.angle[11:8]  = rx_data[3:0];
                        3'd4:    frm_d.angle[7:0]   = rx_data;
                        3'd5:    frm_d.wh           = rx_data[5:0];
                        default: frm_d.color        = rx_data[3:0];
                    endcase
                    if (idx_q == 3'd6) state_d = CSUM;
                    else               idx_d   = idx_q + 3'd1;
                end
                default: begin
                    state_d = HUNT_A;
                    if (rx_data == sum_q && frm_q.x <= X_LIM && frm_q.y <= Y_LIM &&
                        frm_q.wh != 6'd0 && frm_q.wh <= WH_LIM)
                        frame_good = 1'b1;
                    else
                        err_d = 1'b1;
                end
            endcase
        end

        // Skipping the cycle right after a release keeps valid from ever being
        // high on two consecutive cycles when a new frame lands on a release edge.
        release_cmd = pend_q && arm_ready && !valid_q;
        if (release_cmd) begin
            out_d   = buf_q;
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end

        if (frame_good) begin
            buf_d  = frm_q;
            pend_d = 1'b1;
            if (pend_q && !release_cmd && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= HUNT_A;
            idx_q   <= 3'd0;
            sum_q   <= 8'd0;
            gap_q   <= '0;
            frm_q   <= '0;
            buf_q   <= '0;
            out_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            gap_q   <= gap_d;
            frm_q   <= frm_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign x_data        = out_q.x;
    assign y_data        = out_q.y;
    assign angle_bias    = out_q.angle;
    assign warehouse_nob = out_q.wh;
    assign color         = out_q.color;
    assign valid         = valid_q;
    assign frame_err     = err_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_camera_frame_parser.sv
// Bench for camera_frame_parser: directed scenarios plus a randomized run against a
// command-level reference model (frame good/bad, pending slot, drop counter).
// Inputs are driven 1 ns after the rising edge; outputs are observed on the falling edge.
module tb_camera_frame_parser;
    localparam int GAP = 64;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] a;
        logic [5:0]  wh;
        logic [3:0]  c;
    } cmd_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        arm_ready = 1'b0;
    logic [8:0]  x_data;
    logic [7:0]  y_data;
    logic [11:0] angle_bias;
    logic [5:0]  warehouse_nob;
    logic [3:0]  color;
    logic        valid;
    logic        frame_err;
    logic [7:0]  drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    camera_frame_parser #(.GAP_CYCLES(GAP)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .arm_ready(arm_ready), .x_data(x_data), .y_data(y_data), .angle_bias(angle_bias),
        .warehouse_nob(warehouse_nob), .color(color), .valid(valid), .frame_err(frame_err),
        .drop_cnt(drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Output monitor
    cmd_t got_q[$];
    int   err_seen = 0;
    int   dbl_valid = 0;
    logic prev_valid = 1'b0;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (valid) got_q.push_back('{x_data, y_data, angle_bias, warehouse_nob, color});
            if (frame_err) err_seen++;
            if (valid && prev_valid) dbl_valid++;
            prev_valid = valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic send_frame(input cmd_t c, input bit bad_cs, input bit junk, input int maxgap,
                              input bit arm_at_cs);
        logic [7:0] p [7];
        logic [7:0] s;
        p[0] = {(junk ? 7'($urandom) : 7'd0), c.x[8]};
        p[1] = c.x[7:0];
        p[2] = c.y;
        p[3] = {(junk ? 4'($urandom) : 4'd0), c.a[11:8]};
        p[4] = c.a[7:0];
        p[5] = {(junk ? 2'($urandom) : 2'd0), c.wh};
        p[6] = {(junk ? 4'($urandom) : 4'd0), c.c};
        s = 8'd0;
        for (int i = 0; i < 7; i++) s = s + p[i];
        if (bad_cs) s = s + 8'd1;
        send_byte(8'hAA, int'($urandom_range(maxgap, 0)));
        send_byte(8'h55, int'($urandom_range(maxgap, 0)));
        for (int i = 0; i < 7; i++) send_byte(p[i], int'($urandom_range(maxgap, 0)));
        if (arm_at_cs) arm_ready = 1'b1;
        send_byte(s, 0);
    endtask

    function automatic bit in_range(input cmd_t c);
        return c.x <= 9'd319 && c.y <= 8'd239 && c.wh >= 6'd1 && c.wh <= 6'd6;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.x  = 9'($urandom_range(340, 0));
        c.y  = 8'($urandom_range(250, 0));
        c.a  = 12'($urandom);
        c.wh = 6'($urandom_range(7, 0));
        c.c  = 4'($urandom);
        return c;
    endfunction

    function automatic cmd_t good_cmd();
        cmd_t c;
        c.x  = 9'($urandom_range(319, 1));
        c.y  = 8'($urandom_range(239, 1));
        c.a  = 12'($urandom);
        c.wh = 6'($urandom_range(6, 1));
        c.c  = 4'($urandom);
        return c;
    endfunction

    task automatic apply_reset();
        rx_valid  = 1'b0;
        sys_rst_n = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        tick(2);
        sys_rst_n = 1'b1;
        tick(1);
        got_q.delete();
        err_seen  = 0;
        dbl_valid = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({x_data, y_data, angle_bias, warehouse_nob, color} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_cmd: got %h expected 0", {x_data, y_data, angle_bias, warehouse_nob, color});
        end
        vectors++;
        if ({valid, frame_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b expected 00", {valid, frame_err});
        end
        vectors++;
        if (drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_drop: got %0d expected 0", drop_cnt);
        end
        release_reset();
    endtask

    task automatic test_basic();
        logic [7:0] f [10];
        f = '{8'hAA, 8'h55, 8'h00, 8'h84, 8'h50, 8'h00, 8'h10, 8'h01, 8'h02, 8'hE7};
        arm_ready = 1'b1;
        got_q.delete();
        err_seen = 0;
        for (int i = 0; i < 10; i++) send_byte(f[i], (i == 9) ? 0 : int'($urandom_range(2, 0)));
        @(negedge sys_clk);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_valid: got %b expected 0", valid);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: valid got %b expected 1", valid);
        end
        vectors++;
        if ({x_data, y_data, angle_bias, warehouse_nob, color} !== {9'd132, 8'd80, 12'd16, 6'd1, 4'd2}) begin
            miscompares++;
            $display("FAIL basic_fields: got x=%0d y=%0d a=%0d wh=%0d c=%0d expected 132 80 16 1 2",
                     x_data, y_data, angle_bias, warehouse_nob, color);
        end
        tick(3);
        vectors++;
        if (got_q.size() !== 1 || err_seen !== 0) begin
            miscompares++;
            $display("FAIL basic_count: got %0d valids %0d errs expected 1 0", got_q.size(), err_seen);
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] f [10];
        f = '{8'hAA, 8'h55, 8'h00, 8'h84, 8'h50, 8'h00, 8'h10, 8'h01, 8'h02, 8'hE6};
        got_q.delete();
        err_seen = 0;
        for (int i = 0; i < 10; i++) send_byte(f[i], 0);
        tick(4);
        vectors++;
        if (err_seen !== 1 || got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL csum_err: got %0d errs %0d valids expected 1 0", err_seen, got_q.size());
        end
        vectors++;
        if (x_data !== 9'd132 || color !== 4'd2) begin
            miscompares++;
            $display("FAIL csum_hold: got x=%0d c=%0d expected 132 2", x_data, color);
        end
    endtask

    task automatic test_overwrite();
        cmd_t a, b;
        a = '{9'd132, 8'd80, 12'd16, 6'd1, 4'd2};
        b = good_cmd();
        b.x = 9'd200;
        arm_ready = 1'b0;
        got_q.delete();
        send_frame(a, 1'b0, 1'b1, 2, 1'b0);
        send_frame(b, 1'b0, 1'b1, 2, 1'b0);
        tick(4);
        vectors++;
        if (got_q.size() !== 0 || drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL ovw_hold: got %0d valids drop=%0d expected 0 1", got_q.size(), drop_cnt);
        end
        arm_ready = 1'b1;
        tick(4);
        vectors++;
        if (got_q.size() !== 1) begin
            miscompares++;
            $display("FAIL ovw_release_cnt: got %0d expected 1", got_q.size());
        end else if (got_q[0] !== b) begin
            miscompares++;
            $display("FAIL ovw_release_cmd: got %h expected %h", got_q[0], b);
        end
    endtask

    task automatic test_resync_gap();
        cmd_t c, d;
        logic [7:0] f [5];
        c = good_cmd();
        d = good_cmd();
        f = '{8'hAA, 8'h55, 8'h00, 8'h84, 8'h50};
        arm_ready = 1'b1;
        got_q.delete();
        err_seen = 0;
        send_byte(8'h12, 1);
        send_byte(8'hAA, 0);
        send_frame(c, 1'b0, 1'b1, 1, 1'b0);
        tick(4);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== c) begin
            miscompares++;
            $display("FAIL resync: got %0d valids expected 1 with %h", got_q.size(), c);
        end
        for (int i = 0; i < 5; i++) send_byte(f[i], 0);
        tick(GAP - 1);
        vectors++;
        if (err_seen !== 0) begin
            miscompares++;
            $display("FAIL gap_early: got %0d errs expected 0", err_seen);
        end
        tick(2);
        vectors++;
        if (err_seen !== 1) begin
            miscompares++;
            $display("FAIL gap_timeout: got %0d errs expected 1", err_seen);
        end
        send_frame(d, 1'b0, 1'b1, 2, 1'b0);
        tick(4);
        vectors++;
        if (got_q.size() !== 2 || got_q[got_q.size()-1] !== d) begin
            miscompares++;
            $display("FAIL gap_recover: got %0d valids expected 2 ending %h", got_q.size(), d);
        end
    endtask

    task automatic test_range();
        cmd_t tbl [5];
        bit   ok  [5];
        int   e0, n0;
        tbl[0] = '{9'd320, 8'd10,  12'h123, 6'd1, 4'd3};  ok[0] = 1'b0;
        tbl[1] = '{9'd10,  8'd10,  12'h123, 6'd0, 4'd3};  ok[1] = 1'b0;
        tbl[2] = '{9'd10,  8'd10,  12'h123, 6'd7, 4'd3};  ok[2] = 1'b0;
        tbl[3] = '{9'd10,  8'd240, 12'h123, 6'd2, 4'd3};  ok[3] = 1'b0;
        tbl[4] = '{9'd319, 8'd239, 12'hFFF, 6'd6, 4'd15}; ok[4] = 1'b1;
        arm_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e0 = err_seen;
            n0 = got_q.size();
            send_frame(tbl[i], 1'b0, 1'b1, 1, 1'b0);
            tick(4);
            vectors++;
            if (ok[i]) begin
                if (got_q.size() !== n0 + 1 || got_q[got_q.size()-1] !== tbl[i] || err_seen !== e0) begin
                    miscompares++;
                    $display("FAIL range_%0d: got %0d valids %0d errs expected %0d %0d", i,
                             got_q.size() - n0, err_seen - e0, 1, 0);
                end
            end else if (got_q.size() !== n0 || err_seen !== e0 + 1) begin
                miscompares++;
                $display("FAIL range_%0d: got %0d valids %0d errs expected %0d %0d", i,
                         got_q.size() - n0, err_seen - e0, 0, 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        cmd_t a, b;
        logic [7:0] d0;
        a = good_cmd();
        b = good_cmd();
        arm_ready = 1'b0;
        got_q.delete();
        dbl_valid = 0;
        d0 = drop_cnt;
        send_frame(a, 1'b0, 1'b1, 1, 1'b0);
        send_frame(b, 1'b0, 1'b1, 1, 1'b1);
        tick(6);
        vectors++;
        if (got_q.size() !== 2 || got_q[0] !== a || got_q[1] !== b) begin
            miscompares++;
            $display("FAIL simul_order: got %0d valids expected 2 (%h then %h)", got_q.size(), a, b);
        end
        vectors++;
        if (drop_cnt !== d0 || dbl_valid !== 0) begin
            miscompares++;
            $display("FAIL simul_drop: got drop=%0d dbl=%0d expected %0d 0", drop_cnt, dbl_valid, d0);
        end
    endtask

    task automatic test_reset_mid();
        cmd_t e, f;
        logic [7:0] part [4];
        logic [7:0] rest [5];
        e = good_cmd();
        f = good_cmd();
        part = '{8'hAA, 8'h55, 8'h01, 8'h23};
        rest = '{8'h45, 8'h67, 8'h89, 8'h10, 8'h11};
        arm_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(part[i], 0);
        apply_reset();
        vectors++;
        if ({x_data, y_data, angle_bias, warehouse_nob, color, valid, frame_err, drop_cnt} !== 49'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got x=%0d y=%0d drop=%0d expected all 0", x_data, y_data, drop_cnt);
        end
        release_reset();
        for (int i = 0; i < 5; i++) send_byte(rest[i], 0);
        arm_ready = 1'b0;
        send_frame(e, 1'b0, 1'b1, 1, 1'b0);
        tick(4);
        vectors++;
        if (got_q.size() !== 0 || err_seen !== 0) begin
            miscompares++;
            $display("FAIL rst_partial: got %0d valids %0d errs expected 0 0", got_q.size(), err_seen);
        end
        apply_reset();
        release_reset();
        arm_ready = 1'b1;
        tick(5);
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rst_pending: got %0d valids expected 0", got_q.size());
        end
        send_frame(f, 1'b0, 1'b1, 2, 1'b0);
        tick(4);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== f) begin
            miscompares++;
            $display("FAIL rst_recover: got %0d valids expected 1 with %h", got_q.size(), f);
        end
    endtask

    task automatic test_drop_saturate();
        cmd_t c;
        apply_reset();
        release_reset();
        arm_ready = 1'b0;
        c = good_cmd();
        for (int i = 0; i < 258; i++) begin
            c = good_cmd();
            send_frame(c, 1'b0, 1'b1, 0, 1'b0);
        end
        tick(4);
        vectors++;
        if (drop_cnt !== 8'd255 || got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL drop_sat: got drop=%0d valids=%0d expected 255 0", drop_cnt, got_q.size());
        end
        arm_ready = 1'b1;
        tick(4);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== c) begin
            miscompares++;
            $display("FAIL drop_sat_release: got %0d valids expected 1 with %h", got_q.size(), c);
        end
    endtask

    task automatic test_random();
        cmd_t exp_q[$];
        cmd_t c, m_buf;
        bit   m_pend, bad;
        int   m_drop, exp_err, nz;
        logic [7:0] nb;
        apply_reset();
        release_reset();
        arm_ready = 1'b0;
        m_pend = 1'b0;
        m_drop = 0;
        exp_err = 0;
        m_buf = '0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(3, 0) == 0) begin
                arm_ready = ~arm_ready;
                if (arm_ready && m_pend) begin
                    exp_q.push_back(m_buf);
                    m_pend = 1'b0;
                end
                tick(3);
            end
            nz = int'($urandom_range(2, 0));
            for (int k = 0; k < nz; k++) begin
                nb = 8'($urandom);
                if (nb == 8'hAA) nb = 8'h00;
                send_byte(nb, int'($urandom_range(2, 0)));
            end
            c = rand_cmd();
            bad = ($urandom_range(7, 0) == 0);
            send_frame(c, bad, 1'b1, 3, 1'b0);
            tick(4);
            if (bad || !in_range(c)) begin
                exp_err++;
            end else if (arm_ready) begin
                exp_q.push_back(c);
            end else begin
                if (m_pend && m_drop < 255) m_drop++;
                m_buf = c;
                m_pend = 1'b1;
            end
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d valids expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand_cmd_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (err_seen !== exp_err) begin
            miscompares++;
            $display("FAIL rand_err: got %0d expected %0d", err_seen, exp_err);
        end
        vectors++;
        if (int'(drop_cnt) !== m_drop) begin
            miscompares++;
            $display("FAIL rand_drop: got %0d expected %0d", drop_cnt, m_drop);
        end
        vectors++;
        if (dbl_valid !== 0) begin
            miscompares++;
            $display("FAIL rand_dbl_valid: got %0d expected 0", dbl_valid);
        end
    endtask

    initial begin
        tick(2);
        test_reset();
        test_basic();
        test_bad_csum();
        test_overwrite();
        test_resync_gap();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_drop_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
